// File: rtl/timer_pkg.sv
// Shared definitions for the timer command interface: command codes,
// controller state encoding and the state-to-command decode helpers.
package timer_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_CLR  = 2'b01;
  localparam logic [1:0] CTRL_RUN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_e;

  // Timer command issued while the controller sits in a given state.
  function automatic logic [1:0] ctrl_decode(input state_e st);
    logic [1:0] code;
    case (st)
      ST_CLEAR: code = CTRL_CLR;
      ST_RUN:   code = CTRL_RUN;
      default:  code = CTRL_HOLD;
    endcase
    return code;
  endfunction

  // A countdown is in progress (being cleared, counting or frozen).
  function automatic logic busy_decode(input state_e st);
    logic b;
    case (st)
      ST_CLEAR, ST_RUN, ST_PAUSE: b = 1'b1;
      default:                    b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer_ctrl.sv
// Initiator side of the 2-bit timer command interface. Sequences
// clear/run/hold to the timer counter, compares the returned tick count
// against a latched deadline and reports expiry, low-time warning and the
// ticks remaining. ctrl_o/busy_o are registered from the next state so they
// track the state register exactly.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int WARN_LEFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             pause_i,
  input  logic             resume_i,
  input  logic             abort_i,
  input  logic             ack_i,
  input  logic [CNT_W-1:0] tmout_i,
  output logic [1:0]       ctrl_o,
  output logic             busy_o,
  output logic             expired_o,
  output logic             warn_o,
  output logic [CNT_W-1:0] remaining_o
);

  localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_LEFT);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] lim_r, lim_nxt_s;
  logic [CNT_W-1:0] rem_nxt_s;
  logic             warn_nxt_s;
  logic             expired_nxt_s;
  logic [1:0]       ctrl_r;
  logic             busy_r;
  logic             expired_r;
  logic             warn_r;
  logic [CNT_W-1:0] rem_r;

  // Next state and deadline latch; priority abort > start > expiry > pause > resume > ack.
  always_comb begin
    state_nxt_s = state_r;
    lim_nxt_s   = lim_r;
    if (abort_i) begin
      state_nxt_s = ST_IDLE;
    end else if (start_i) begin
      lim_nxt_s = limit_i;
      if (limit_i == ZERO_V) begin
        state_nxt_s = ST_EXPIRED;
      end else begin
        state_nxt_s = ST_CLEAR;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_CLEAR: begin
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          // >= also catches a stale or overshooting count
          if (tmout_i >= lim_r) begin
            state_nxt_s = ST_EXPIRED;
          end else if (pause_i) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (resume_i) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          if (ack_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_EXPIRED;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Status values to register: remaining ticks, warning and expiry pulse.
  always_comb begin
    rem_nxt_s     = ZERO_V;
    warn_nxt_s    = 1'b0;
    expired_nxt_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        rem_nxt_s = lim_r;
      end
      ST_RUN, ST_PAUSE: begin
        if (tmout_i >= lim_r) begin
          rem_nxt_s = ZERO_V;
        end else begin
          rem_nxt_s = lim_r - tmout_i;
        end
      end
      default: begin
        rem_nxt_s = ZERO_V;
      end
    endcase
    if ((state_r == ST_RUN || state_r == ST_PAUSE) &&
        (rem_nxt_s != ZERO_V) && (rem_nxt_s <= WARN_V)) begin
      warn_nxt_s = 1'b1;
    end else begin
      warn_nxt_s = 1'b0;
    end
    if ((state_nxt_s == ST_EXPIRED) && (state_r != ST_EXPIRED)) begin
      expired_nxt_s = 1'b1;
    end else begin
      expired_nxt_s = 1'b0;
    end
  end

  // State register, deadline and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      lim_r     <= ZERO_V;
      ctrl_r    <= CTRL_HOLD;
      busy_r    <= 1'b0;
      expired_r <= 1'b0;
      warn_r    <= 1'b0;
      rem_r     <= ZERO_V;
    end else begin
      state_r   <= state_nxt_s;
      lim_r     <= lim_nxt_s;
      ctrl_r    <= ctrl_decode(state_nxt_s);
      busy_r    <= busy_decode(state_nxt_s);
      expired_r <= expired_nxt_s;
      warn_r    <= warn_nxt_s;
      rem_r     <= rem_nxt_s;
    end
  end

  assign ctrl_o      = ctrl_r;
  assign busy_o      = busy_r;
  assign expired_o   = expired_r;
  assign warn_o      = warn_r;
  assign remaining_o = rem_r;

endmodule
